inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: issues word-aligned fetches under a credit limit and buffers
// returned words with their PCs in a small FIFO for decode. Redirects flush the
// buffer and discard responses still in flight.
`ifndef XLEN
`define XLEN 32
`endif

module inst_fetch #(
  parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [`XLEN-1:0] imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [`XLEN-1:0] imem_resp_data,
  input  logic             redirect,
  input  logic [`XLEN-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [`XLEN-1:0] instruction,
  output logic [`XLEN-1:0] inst_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);

  logic [`XLEN-1:0] fetch_pc;
  logic [`XLEN-1:0] resp_pc;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop_cnt;

  logic [`XLEN-1:0] pc_mem   [DEPTH];
  logic [`XLEN-1:0] word_mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    fifo_count;

  logic             fifo_empty;
  logic             fifo_full;
  logic             credit_ok;
  logic             req_fire;
  logic             push;
  logic             pop;
  logic [CW-1:0]    resp_dec;
  logic [`XLEN-1:0] redirect_target;

  // Credits cover both words in flight and words already buffered, so a
  // returning response always finds a free slot.
  always_comb begin
    fifo_empty      = (fifo_count == '0);
    fifo_full       = (fifo_count == FULL_COUNT);
    credit_ok       = (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDIT_LIMIT);
    imem_req_valid  = !rst && !redirect && credit_ok;
    imem_req_addr   = fetch_pc;
    req_fire        = imem_req_valid && imem_req_ready;
    resp_dec        = CW'(imem_resp_valid);
    push            = !rst && !redirect && imem_resp_valid && (drop_cnt == '0);
    inst_valid      = !rst && !fifo_empty;
    pop             = !redirect && inst_valid && inst_ready;
    instruction     = word_mem[rd_ptr];
    inst_pc         = pc_mem[rd_ptr];
    redirect_target = {redirect_pc[`XLEN-1:2], 2'b00};
  end

  // A response landing in the redirect cycle is already stale, hence it is
  // removed from the in-flight count before that count becomes the drop budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_target;
      resp_pc     <= redirect_target;
      outstanding <= outstanding - resp_dec;
      drop_cnt    <= outstanding - resp_dec;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + `XLEN'(4);
      end
      outstanding <= outstanding + CW'(req_fire) - resp_dec;
      if (imem_resp_valid) begin
        if (drop_cnt == '0) begin
          resp_pc <= resp_pc + `XLEN'(4);
        end else begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      word_mem[wr_ptr] <= imem_resp_data;
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

  no_unrequested_resp: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp_valid && (outstanding == '0)));

endmodule
